// File: rtl/rpc2_ctrl_axi_rd_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rpc2_ctrl_axi_rd_resp
// Brief   : AXI R-channel generator fed by the AXI-ID and read-data FIFOs.
// Revision: 1.0 - initial release
// ============================================================================
module rpc2_ctrl_axi_rd_resp #(
    parameter int C_ID_WIDTH   = 4,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_LEN_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          axid_rd_en,
    input  logic [C_ID_WIDTH+C_LEN_WIDTH-1:0] axid_rd_data,
    input  logic                          axid_empty,
    output logic                          rdat_rd_en,
    input  logic [C_DATA_WIDTH:0]         rdat_rd_data,
    input  logic                          rdat_empty,
    output logic [C_ID_WIDTH-1:0]         rid,
    output logic [C_DATA_WIDTH-1:0]       rdata,
    output logic [1:0]                    rresp,
    output logic                          rlast,
    output logic                          rvalid,
    input  logic                          rready
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_id_load = 2'd1;
    localparam logic [1:0] c_st_active  = 2'd2;
    localparam logic [C_LEN_WIDTH:0] c_pops_one = {{C_LEN_WIDTH{1'b0}}, 1'b1};

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [C_ID_WIDTH-1:0]   r_cur_id;
    logic [C_LEN_WIDTH:0]    r_pops_left;
    logic                    r_inflight;
    logic [C_ID_WIDTH-1:0]   r_pend_id;
    logic                    r_pend_last;
    logic [1:0]              r_occ;
    logic [C_ID_WIDTH-1:0]   r_rid;
    logic [C_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]              r_rresp;
    logic                    r_rlast;
    logic [C_ID_WIDTH-1:0]   r_b_id;
    logic [C_DATA_WIDTH-1:0] r_b_data;
    logic [1:0]              r_b_resp;
    logic                    r_b_last;
    logic                    w_axid_rd_en;
    logic                    w_rdat_rd_en;
    logic                    w_last_pop;
    logic                    w_hs;
    logic                    w_credit_ok;
    logic [1:0]              w_new_resp;

    assign rvalid = (r_occ != 2'd0);
    assign w_hs   = rvalid && rready;
    // Pops in flight plus held entries must never exceed the two buffer slots.
    assign w_credit_ok = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_hs});
    assign w_new_resp  = rdat_rd_data[C_DATA_WIDTH] ? 2'b10 : 2'b00;

    assign axid_rd_en = w_axid_rd_en;
    assign rdat_rd_en = w_rdat_rd_en;
    assign rid   = r_rid;
    assign rdata = r_rdata;
    assign rresp = r_rresp;
    assign rlast = r_rlast;

    always_comb begin
        w_state_next = r_state;
        w_axid_rd_en = 1'b0;
        w_rdat_rd_en = 1'b0;
        w_last_pop   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (!axid_empty && !rst) begin
                    w_axid_rd_en = 1'b1;
                    w_state_next = c_st_id_load;
                end
            end
            c_st_id_load: w_state_next = c_st_active;
            c_st_active: begin
                if ((|r_pops_left) && !rdat_empty && w_credit_ok && !rst) begin
                    w_rdat_rd_en = 1'b1;
                    if (r_pops_left == c_pops_one) begin
                        w_last_pop   = 1'b1;
                        w_state_next = c_st_idle;
                    end
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cur_id    <= '0;
            r_pops_left <= '0;
            r_inflight  <= 1'b0;
            r_pend_id   <= '0;
            r_pend_last <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_inflight  <= w_rdat_rd_en;
            r_pend_id   <= r_cur_id;
            r_pend_last <= w_last_pop;
            if (r_state == c_st_id_load) begin
                r_cur_id    <= axid_rd_data[C_ID_WIDTH+C_LEN_WIDTH-1 -: C_ID_WIDTH];
                r_pops_left <= {1'b0, axid_rd_data[C_LEN_WIDTH-1:0]} + c_pops_one;
            end else if (w_rdat_rd_en) begin
                r_pops_left <= r_pops_left - c_pops_one;
            end
        end
    end

    // Head entry lives in the output registers; the second slot backs it up.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ    <= 2'd0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
            r_rlast  <= 1'b0;
            r_b_id   <= '0;
            r_b_data <= '0;
            r_b_resp <= 2'b00;
            r_b_last <= 1'b0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (r_inflight) begin
                        r_rid   <= r_pend_id;
                        r_rdata <= rdat_rd_data[C_DATA_WIDTH-1:0];
                        r_rresp <= w_new_resp;
                        r_rlast <= r_pend_last;
                        r_occ   <= 2'd1;
                    end
                end
                2'd1: begin
                    if (r_inflight && w_hs) begin
                        r_rid   <= r_pend_id;
                        r_rdata <= rdat_rd_data[C_DATA_WIDTH-1:0];
                        r_rresp <= w_new_resp;
                        r_rlast <= r_pend_last;
                    end else if (r_inflight) begin
                        r_b_id   <= r_pend_id;
                        r_b_data <= rdat_rd_data[C_DATA_WIDTH-1:0];
                        r_b_resp <= w_new_resp;
                        r_b_last <= r_pend_last;
                        r_occ    <= 2'd2;
                    end else if (w_hs) begin
                        r_occ <= 2'd0;
                    end
                end
                default: begin
                    if (w_hs) begin
                        r_rid   <= r_b_id;
                        r_rdata <= r_b_data;
                        r_rresp <= r_b_resp;
                        r_rlast <= r_b_last;
                        if (r_inflight) begin
                            r_b_id   <= r_pend_id;
                            r_b_data <= rdat_rd_data[C_DATA_WIDTH-1:0];
                            r_b_resp <= w_new_resp;
                            r_b_last <= r_pend_last;
                        end else begin
                            r_occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rpc2_ctrl_axi_rd_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_rpc2_ctrl_axi_rd_resp
// Brief   : Self-checking bench with FIFO models and an expected-beat queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rpc2_ctrl_axi_rd_resp;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        axid_rd_en;
    logic [11:0] axid_rd_data = '0;
    logic        axid_empty = 1'b1;
    logic        rdat_rd_en;
    logic [32:0] rdat_rd_data = '0;
    logic        rdat_empty = 1'b1;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;

    logic [11:0] axid_q[$];
    logic [32:0] rdat_q[$];
    beat_t       exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rready_mode = 0;
    int n_beats = 0;
    int n_axid_pops = 0;
    int n_rdat_pops = 0;
    int hs_first = -1;
    int hs_last = -1;
    bit hold = 1'b0;
    beat_t h_beat;
    beat_t e_beat;

    rpc2_ctrl_axi_rd_resp #(
        .C_ID_WIDTH  (4),
        .C_DATA_WIDTH(32),
        .C_LEN_WIDTH (8)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .axid_rd_en  (axid_rd_en),
        .axid_rd_data(axid_rd_data),
        .axid_empty  (axid_empty),
        .rdat_rd_en  (rdat_rd_en),
        .rdat_rd_data(rdat_rd_data),
        .rdat_empty  (rdat_empty),
        .rid         (rid),
        .rdata       (rdata),
        .rresp       (rresp),
        .rlast       (rlast),
        .rvalid      (rvalid),
        .rready      (rready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO models: data appears the cycle after a pop.
    always @(posedge clk) begin
        if (axid_rd_en) begin
            check_val("axid_pop_nonempty", 64'(axid_q.size() != 0), 1);
            if (axid_q.size() != 0) begin
                axid_rd_data <= axid_q.pop_front();
                n_axid_pops++;
            end
        end
        if (rdat_rd_en) begin
            check_val("rdat_pop_nonempty", 64'(rdat_q.size() != 0), 1);
            if (rdat_q.size() != 0) begin
                rdat_rd_data <= rdat_q.pop_front();
                n_rdat_pops++;
            end
        end
    end

    always @(negedge clk) begin
        axid_empty = (axid_q.size() == 0);
        rdat_empty = (rdat_q.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        case (rready_mode)
            1:       rready = 1'($urandom_range(0, 1));
            2:       rready = (cyc % 3 == 0);
            default: rready = 1'b1;
        endcase
    end

    // Monitor: sampled mid-cycle, reflects the handshake at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check_val("hold_rvalid", rvalid, 1);
                check_val("hold_rid", rid, h_beat.id);
                check_val("hold_rdata", rdata, h_beat.data);
                check_val("hold_rresp", rresp, h_beat.resp);
                check_val("hold_rlast", rlast, h_beat.last);
            end
            if (rvalid && rready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", 1, 0);
                end else begin
                    e_beat = exp_q.pop_front();
                    check_val("rid", rid, e_beat.id);
                    check_val("rdata", rdata, e_beat.data);
                    check_val("rresp", rresp, e_beat.resp);
                    check_val("rlast", rlast, e_beat.last);
                end
                n_beats++;
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
                hold = 1'b0;
            end else if (rvalid) begin
                hold = 1'b1;
                h_beat.id   = rid;
                h_beat.data = rdata;
                h_beat.resp = rresp;
                h_beat.last = rlast;
            end else begin
                hold = 1'b0;
            end
        end
    end

    // Reference model: each descriptor expands to len+1 beats, last on the final one.
    task automatic push_burst(input logic [3:0] id, input int len, input int err_beat,
                              input int gap_max, input logic [31:0] data0, input bit rnd);
        beat_t b;
        logic [31:0] d;
        logic        e;
        logic [7:0]  l8;
        l8 = len[7:0];
        axid_q.push_back({id, l8});
        for (int i = 0; i <= len; i++) begin
            d = rnd ? $urandom : data0 + 32'(i);
            e = (i == err_beat);
            rdat_q.push_back({e, d});
            b.id   = id;
            b.data = d;
            b.resp = e ? 2'b10 : 2'b00;
            b.last = (i == len);
            exp_q.push_back(b);
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #2;
                end
            end
        end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && axid_q.size() == 0 && rdat_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        check_val(tag, 64'(exp_q.size()), 0);
        repeat (4) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        // Reset values, with both FIFOs non-empty while reset is held.
        repeat (2) @(posedge clk);
        #2;
        push_burst(4'h3, 0, -1, 0, 32'hA5A5_0001, 1'b0);
        @(posedge clk);
        #2;
        @(negedge clk);
        check_val("rst_rvalid", rvalid, 0);
        check_val("rst_rlast", rlast, 0);
        check_val("rst_rid", rid, 0);
        check_val("rst_rdata", rdata, 0);
        check_val("rst_rresp", rresp, 0);
        check_val("rst_axid_rd_en", axid_rd_en, 0);
        check_val("rst_rdat_rd_en", rdat_rd_en, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single beat.
        wait_drain("drain_single", 50);
        check_val("single_axid_pops", n_axid_pops, 1);
        check_val("single_rdat_pops", n_rdat_pops, 1);

        // Back-to-back bursts, pre-filled, full rate.
        hs_first = -1;
        push_burst(4'h1, 3, -1, 0, 32'h1000_0000, 1'b0);
        push_burst(4'h2, 1, -1, 0, 32'h2000_0000, 1'b0);
        wait_drain("drain_b2b", 100);
        check_val("b2b_span_le_7", 64'((hs_last - hs_first) <= 7), 1);

        // Backpressure pattern 1,0,0,...
        rready_mode = 2;
        push_burst(4'h7, 7, -1, 0, 32'h3000_0000, 1'b0);
        wait_drain("drain_bp", 200);

        // Error on beat 2 of a 4-beat burst.
        rready_mode = 0;
        push_burst(4'hA, 3, 1, 0, 32'h4000_0000, 1'b0);
        wait_drain("drain_err", 100);

        // Maximum length burst.
        push_burst(4'hF, 255, -1, 0, 32'h0, 1'b1);
        wait_drain("drain_max", 1000);

        // Randomised bursts with trickled data and random rready.
        rready_mode = 1;
        for (int k = 0; k < 12; k++) begin
            int ln;
            ln = $urandom_range(0, 15);
            push_burst(4'($urandom_range(0, 15)), ln,
                       ($urandom_range(0, 1) != 0) ? $urandom_range(0, ln) : -1,
                       2, 32'h0, 1'b1);
        end
        wait_drain("drain_rand", 2000);

        // Reset after beat 2 of an 8-beat burst.
        rready_mode = 0;
        base = n_beats;
        push_burst(4'h5, 7, -1, 0, 32'h5000_0000, 1'b0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #2;
            if (n_beats >= base + 2) break;
        end
        check_val("rst_mid_reached", 64'(n_beats >= base + 2), 1);
        rst = 1'b1;
        axid_q.delete();
        rdat_q.delete();
        exp_q.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_mid_rvalid", rvalid, 0);
        check_val("rst_mid_rlast", rlast, 0);
        @(posedge clk);
        #2;
        push_burst(4'h9, 2, 1, 0, 32'hC0DE_0000, 1'b0);
        wait_drain("drain_after_rst", 100);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rpc2_ctrl_axi_rd_resp.md
# rpc2_ctrl_axi_rd_resp

AXI read-response generator for the RPC2 controller. Pops burst descriptors {ARID, ARLEN} from the AXI-ID FIFO and read beats {data, error} from the read-data FIFO, then drives the AXI R channel with correct RID, RRESP and RLAST. Sits directly downstream of the AXI-ID FIFO and the read-data FIFO, and upstream of the AXI slave port. Sustains one beat per cycle with RREADY held high.

## Interface
Parameters:
- C_ID_WIDTH, 4, AXI ID width
- C_DATA_WIDTH, 32, AXI read-data width
- C_LEN_WIDTH, 8, ARLEN width; beats per burst = ARLEN+1

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- axid_rd_en  out  1  pop request to the AXI-ID FIFO
- axid_rd_data  in  C_ID_WIDTH+C_LEN_WIDTH  {id, len}; valid the cycle after a pop
- axid_empty  in  1  AXI-ID FIFO empty
- rdat_rd_en  out  1  pop request to the read-data FIFO
- rdat_rd_data  in  C_DATA_WIDTH+1  {err, data}; valid the cycle after a pop
- rdat_empty  in  1  read-data FIFO empty
- rid  out  C_ID_WIDTH  AXI RID
- rdata  out  C_DATA_WIDTH  AXI RDATA
- rresp  out  2  AXI RRESP: 2'b00 OKAY, 2'b10 SLVERR
- rlast  out  1  AXI RLAST
- rvalid  out  1  AXI RVALID
- rready  in  1  AXI RREADY

## Operation
- FSM states: IDLE, ID_LOAD, ACTIVE.
- IDLE:
  - axid_rd_en = !axid_empty.
  - If asserted, go to ID_LOAD.
- ID_LOAD:
  - Capture cur_id = axid_rd_data[top C_ID_WIDTH bits].
  - Capture pops_left = len+1 in a (C_LEN_WIDTH+1)-bit counter, so len=255 gives 256.
  - Go to ACTIVE.
- ACTIVE:
  - rdat_rd_en = (pops_left != 0) && !rdat_empty && credit_ok.
  - Each pop decrements pops_left.
  - The pop that brings pops_left to 0 tags its beat last=1, and the FSM goes to IDLE in the same cycle.
  - The next descriptor may therefore be fetched while earlier beats are still draining.
- Credit:
  - credit_ok = (occ + inflight - (rvalid && rready)) < 2.
  - occ is the number of output-buffer entries held, 0..2.
  - inflight = 1 in the cycle after an rdat_rd_en.
- Output buffer:
  - 2-entry in-order buffer; each entry holds {id, data, resp, last}.
  - The cycle after a pop, rdat_rd_data is written with id = cur_id of the issuing burst, resp = err ? 2'b10 : 2'b00, and last = tag.
  - R outputs are driven from registers holding the head entry. rvalid = (occ != 0).
- Both rd_en outputs are 0 while rst=1.
- A pop is never issued to an empty FIFO.

## Timing
- Reset values: rvalid=0, rlast=0, rid=0, rdata=0, rresp=0, axid_rd_en=0, rdat_rd_en=0.
- Reset internal state: FSM=IDLE, occ=0, inflight=0, pops_left=0.
- Latency from rdat_rd_en to rvalid of that beat (buffer empty): 2 cycles.
- Latency from axid_rd_en to first rdat_rd_en: 2 cycles, if data is available.
- Handshake:
  - Once rvalid=1, rid, rdata, rresp and rlast are held stable until the cycle rvalid && rready.
  - rvalid never deasserts without a handshake.
- Throughput: with rready=1 and both FIFOs non-empty, one beat per cycle within a burst.
- Burst boundary: one IDLE cycle plus one ID_LOAD cycle, which costs at most 2 bubbles per burst.
- Simultaneous buffer write and handshake in one cycle: occ is unchanged, and the head advances to the next entry.
- rdat_empty mid-burst: pops pause, and rvalid drops only after the buffer is empty. The burst resumes with the correct id and last tag.
- Reset mid-burst: all buffered beats and counters are discarded and outputs return to reset values the next cycle. FIFO contents are reset by their own owner.

## Test plan
- Single beat: descriptor {id=4'h3, len=0}, data 32'hA5A5_0001 with err=0, rready=1. Expect one beat rid=3, rdata=32'hA5A5_0001, rresp=00, rlast=1, and exactly one pop from each FIFO.
- Back-to-back bursts at full rate: descriptors {id=1, len=3} and {id=2, len=1}, both FIFOs pre-filled, rready=1. Expect 4 beats with rid=1 (rlast on the 4th) then 2 beats with rid=2, at most 2 rvalid bubbles between the bursts, and in-order data.
- Backpressure: burst of len=7 with rready toggling 1,0,0,1,…. Expect R outputs stable while rvalid && !rready, occ never above 2, and no beat lost or duplicated.
- Error beat: 4-beat burst with err=1 on beat 2. Expect rresp=10 on beat 2 only; all other beats 00.
- Maximum length: len=255. Expect 256 beats, rlast only on beat 256, and pops_left wraps to 0 without overflow.
- Reset mid-burst: assert rst for 1 cycle after beat 2 of an 8-beat burst. Expect rvalid=0 the next cycle, then clean processing of a fresh descriptor.
